// File: rtl/key_filter_if.sv
// rtl/key_filter_if.sv - raw key pins in, debounced press pulse and level out
interface key_filter_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_flag;
  logic [N_KEYS-1:0] key_level;

  modport master (output key_in, input key_flag, input key_level);
  modport slave  (input key_in, output key_flag, output key_level);
endinterface

// File: rtl/key_filter.sv
// rtl/key_filter.sv - per-key 2-flop synchroniser and debounce FSM with press pulse/level
// Auto-repeat while held is compiled in only when KEY_REPEAT_EN is defined.
module key_filter #(
  parameter int N_KEYS        = 4,
  parameter int CNT_MAX       = 999_999,
  parameter int REPEAT_DELAY  = 24_999_999,
  parameter int REPEAT_PERIOD = 4_999_999
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  key_filter_if.slave  keys
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  // The cycle in which IDLE/HELD first sees the new level counts as the first
  // stable cycle, so the filter terminates one count early.
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_FILT = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keys.key_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          flag_q, flag_nxt;
    logic          level_q, level_nxt;
    logic          s;

    assign s = sync2[g];

`ifdef KEY_REPEAT_EN
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          phase, phase_nxt;
    logic [RW-1:0] rterm;

    assign rterm = phase ? R_PERIOD : R_DELAY;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        rcnt  <= '0;
        phase <= 1'b0;
      end else begin
        rcnt  <= rcnt_nxt;
        phase <= phase_nxt;
      end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state   <= IDLE;
        cnt     <= '0;
        flag_q  <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        flag_q  <= flag_nxt;
        level_q <= level_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      flag_nxt  = 1'b0;
      level_nxt = level_q;
`ifdef KEY_REPEAT_EN
      rcnt_nxt  = rcnt;
      phase_nxt = phase;
`endif
      case (state)
        IDLE: begin
          if (!s) begin
            state_nxt = PRESS_FILT;
            cnt_nxt   = '0;
          end
        end
        PRESS_FILT: begin
          if (s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            flag_nxt  = 1'b1;
            level_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HELD: begin
          if (s) begin
            state_nxt = RELEASE_FILT;
            cnt_nxt   = '0;
`ifdef KEY_REPEAT_EN
            rcnt_nxt  = '0;
          end else if (rcnt == rterm) begin
            // First hit ends the delay phase; later hits use the period.
            flag_nxt  = 1'b1;
            rcnt_nxt  = '0;
            phase_nxt = 1'b1;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
`endif
          end
        end
        RELEASE_FILT: begin
          if (!s) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
`ifdef KEY_REPEAT_EN
            rcnt_nxt  = '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
`ifdef KEY_REPEAT_EN
            phase_nxt = 1'b0;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign keys.key_flag[g]  = flag_q;
    assign keys.key_level[g] = level_q;
  end

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - directed and random stimulus for key_filter against a run-length model
module tb_key_filter;
  localparam int NK = 4;
  localparam int CM = 9;
  localparam int RD = 49;
  localparam int RP = 19;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  key_filter_if #(.N_KEYS(NK)) bus ();

  key_filter #(.N_KEYS(NK), .CNT_MAX(CM), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .keys      (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: a key's level flips once its synchronised input has disagreed
  // with the level for CM+1 consecutive cycles.
  logic [NK-1:0] m_s1, m_s2, m_level, m_flag;
  int m_run[NK];
  int m_elapsed[NK];
  bit m_phase[NK];
  int pulses[NK];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0; m_flag = '0;
    for (int i = 0; i < NK; i++) begin
      m_run[i] = 0; m_elapsed[i] = 0; m_phase[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] s;
    logic pressed;
    s = m_s2; m_s2 = m_s1; m_s1 = bus.key_in; m_flag = '0;
    for (int k = 0; k < NK; k++) begin
      pressed = ~s[k];
      if (pressed != m_level[k]) begin
        m_elapsed[k] = 0;
        m_run[k]++;
        if (m_run[k] == CM + 1) begin
          m_run[k]   = 0;
          m_level[k] = pressed;
          m_flag[k]  = pressed;
          if (!pressed) m_phase[k] = 1'b0;
        end
      end else begin
        if (m_level[k] && m_run[k] == 0) begin
`ifdef KEY_REPEAT_EN
          m_elapsed[k]++;
          if (m_elapsed[k] == (m_phase[k] ? RP : RD) + 1) begin
            m_flag[k] = 1'b1; m_elapsed[k] = 0; m_phase[k] = 1'b1;
          end
`endif
        end else begin
          m_elapsed[k] = 0;
        end
        m_run[k] = 0;
      end
    end
  endtask

  task automatic cycle(input logic [NK-1:0] k);
    bus.key_in = k;
    @(posedge sys_clk);
    if (sys_rst_n) model_edge();
    @(negedge sys_clk);
    cyc++;
    chk("key_flag", 32'(bus.key_flag), 32'(m_flag));
    chk("key_level", 32'(bus.key_level), 32'(m_level));
    for (int i = 0; i < NK; i++) pulses[i] += int'(bus.key_flag[i]);
  endtask

  task automatic hold(input logic [NK-1:0] k, input int n);
    repeat (n) cycle(k);
  endtask

  // Edges until key_flag[idx] first rises (-1 if not within the bound).
  task automatic latency(input logic [NK-1:0] k, input int idx, output int edges,
                         output logic [NK-1:0] flags);
    edges = -1; flags = '0;
    for (int i = 1; i <= 40; i++) begin
      cycle(k);
      if (edges < 0 && bus.key_flag[idx]) begin
        edges = i; flags = bus.key_flag;
      end
    end
  endtask

  task automatic async_reset(input logic [NK-1:0] k, input int n);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("reset_flag_now", 32'(bus.key_flag), 32'h0);
    chk("reset_level_now", 32'(bus.key_level), 32'h0);
    model_reset();
    hold(k, n);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int e, p, exp_rep;
    logic [NK-1:0] fl, keys_q;
    int dur[NK];

    for (int i = 0; i < NK; i++) pulses[i] = 0;
    model_reset();

    // Reset held with keys low, then released: all four pulse together.
    bus.key_in = '0;
    hold(4'b0000, 5);
    chk("reset_flag", 32'(bus.key_flag), 32'h0);
    chk("reset_level", 32'(bus.key_level), 32'h0);
    sys_rst_n = 1'b1;
    latency(4'b0000, 0, e, fl);
    chk("reset_release_latency", 32'(e), 32'd12);
    chk("reset_release_all_keys", 32'(fl), 32'hf);
    hold(4'b1111, 20);

    // Clean press and release of key 0.
    latency(4'b1110, 0, e, fl);
    chk("press_latency", 32'(e), 32'd12);
    chk("press_level", 32'(bus.key_level[0]), 32'd1);
    p = pulses[0]; e = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(4'b1111);
      if (e < 0 && !bus.key_level[0]) e = i;
    end
    chk("release_latency", 32'(e), 32'd12);
    chk("release_no_pulse", 32'(pulses[0] - p), 32'd0);

    // Bounce on key 1 never reaches a full filter window.
    p = pulses[1];
    hold(4'b1101, 6); hold(4'b1111, 2); hold(4'b1101, 6); hold(4'b1111, 20);
    chk("bounce_no_pulse", 32'(pulses[1] - p), 32'd0);
    chk("bounce_level", 32'(bus.key_level[1]), 32'd0);

    // Short release glitch on a held key 2.
    hold(4'b1011, 15);
    p = pulses[2];
    hold(4'b1111, 3); hold(4'b1011, 20);
    chk("glitch_no_pulse", 32'(pulses[2] - p), 32'd0);
    chk("glitch_level", 32'(bus.key_level[2]), 32'd1);
    hold(4'b1111, 20);

    // Key 3 held 200 cycles past its press pulse.
    p = pulses[3];
    hold(4'b0111, 212);
`ifdef KEY_REPEAT_EN
    exp_rep = 9;
`else
    exp_rep = 1;
`endif
    chk("hold_pulse_count", 32'(pulses[3] - p), 32'(exp_rep));
    hold(4'b1111, 20);

    // Reset while key 0 filters at count 5 and key 2 is held.
    hold(4'b1011, 20);
    hold(4'b1010, 8);
    async_reset(4'b1010, 3);
    latency(4'b1010, 0, e, fl);
    chk("midfilter_reset_latency", 32'(e), 32'd12);
    hold(4'b1111, 20);

    // Random key activity with occasional asynchronous resets.
    keys_q = '1;
    for (int i = 0; i < NK; i++) dur[i] = $urandom_range(1, 20);
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NK; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          keys_q[i] = ~keys_q[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 120) : $urandom_range(1, 14);
        end
      end
      if ($urandom_range(0, 599) == 0) async_reset(keys_q, $urandom_range(1, 4));
      else cycle(keys_q);
    end
    hold(4'b1111, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
